// File: rtl/rom_rd_arbiter.sv
// Read arbiter sharing one combinational-read lookup ROM among NREQ requesters.
// Round-robin by default; define ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module rom_rd_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 3,
  parameter int DW   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DW-1:0]        rsp_data,
  output logic [AW-1:0]        rom_addr,
  input  logic [DW-1:0]        rom_data,
  output logic                 busy
);

  localparam int IW = (NREQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       gnt_id_q, gnt_id_d;
  logic [AW-1:0]       rom_addr_q, rom_addr_d;
  logic [DW-1:0]       rsp_data_q, rsp_data_d;
  logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic                busy_q, busy_d;
  logic [NREQ-1:0]     req_ready_s;
  logic [IW-1:0]       win_s;
  logic                win_found_s;

`ifndef ARB_FIXED_PRIO_EN
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = (32'(base) + off) % 32'(NREQ);
    return IW'(sum);
  endfunction
`endif

  // Winner selection among currently valid requesters
  always_comb begin
    win_found_s = 1'b0;
    win_s       = '0;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found_s && req_valid[i]) begin
        win_found_s = 1'b1;
        win_s       = IW'(i);
      end else begin
        win_found_s = win_found_s;
      end
    end
`else
    // Search starts one past the last winner so every requester gets a turn
    for (int i = 1; i <= NREQ; i++) begin
      if (!win_found_s && req_valid[rr_idx(rr_ptr_q, 32'(i))]) begin
        win_found_s = 1'b1;
        win_s       = rr_idx(rr_ptr_q, 32'(i));
      end else begin
        win_found_s = win_found_s;
      end
    end
`endif
  end

  // Next-state and handshake decode
  always_comb begin
    state_d     = state_q;
    gnt_id_d    = gnt_id_q;
    rom_addr_d  = rom_addr_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = '0;
    req_ready_s = '0;
`ifndef ARB_FIXED_PRIO_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          req_ready_s[win_s] = 1'b1;
          rom_addr_d         = req_addr[win_s*AW +: AW];
          gnt_id_d           = win_s;
`ifndef ARB_FIXED_PRIO_EN
          rr_ptr_d           = win_s;
`endif
          state_d            = ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        rsp_data_d            = rom_data;
        rsp_valid_d[gnt_id_q] = 1'b1;
        state_d               = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; an in-flight read is dropped on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_id_q    <= '0;
      rom_addr_q  <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr_q    <= IW'(NREQ - 1);
`endif
    end else begin
      state_q     <= state_d;
      gnt_id_q    <= gnt_id_d;
      rom_addr_q  <= rom_addr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  assign req_ready = req_ready_s;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rom_addr  = rom_addr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rom_rd_arbiter.sv
// Directed bench for rom_rd_arbiter with a local 8x4 ROM model (entry i = 2*i).
module tb_rom_rd_arbiter;
  localparam int NREQ = 2;
  localparam int AW   = 3;
  localparam int DW   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic [AW-1:0]     rom_addr;
  logic [DW-1:0]     rom_data;
  logic              busy;
  logic [DW-1:0]     rom_mem [0:7];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign rom_data = rom_mem[rom_addr];

  rom_rd_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .busy      (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] exp_ready;
    logic [3:0] exp_data;

    for (int i = 0; i < 8; i++) rom_mem[i] = DW'(2 * i);
    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_rsp_data",  32'(rsp_data),  32'd0);
    check_val("rst_rom_addr",  32'(rom_addr),  32'd0);
    check_val("rst_busy",      32'(busy),      32'd0);
    check_val("rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single read from requester 0, addr 5
    @(negedge clk);
    req_valid = 2'b01;
    req_addr  = 6'd5;
    #1;
    check_val("single_ready", 32'(req_ready), 32'd1);
    check_val("single_busy_T", 32'(busy), 32'd0);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check_val("single_busy_T1", 32'(busy), 32'd1);
    check_val("single_rom_addr", 32'(rom_addr), 32'd5);
    check_val("single_ready_T1", 32'(req_ready), 32'd0);
    check_val("single_rsp_T1", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    #1;
    check_val("single_rsp_valid", 32'(rsp_valid), 32'd1);
    check_val("single_rsp_data", 32'(rsp_data), 32'd10);
    check_val("single_busy_T2", 32'(busy), 32'd1);
    @(negedge clk);
    #1;
    check_val("single_rsp_clear", 32'(rsp_valid), 32'd0);
    check_val("single_busy_T3", 32'(busy), 32'd0);
    check_val("single_data_hold", 32'(rsp_data), 32'd10);

    // reset pulse so the arbitration pointer starts fresh
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // both requesters valid continuously: addr0=1, addr1=7
    @(negedge clk);
    req_valid = 2'b11;
    req_addr  = {3'd7, 3'd1};
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_FIXED_PRIO_EN
      exp_ready = 2'b01;
      exp_data  = 4'd2;
`else
      exp_ready = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_data  = (k % 2 == 0) ? 4'd2 : 4'd14;
`endif
      #1;
      check_val("both_ready", 32'(req_ready), 32'(exp_ready));
      @(negedge clk);
      #1;
      check_val("both_ready_read", 32'(req_ready), 32'd0);
      @(negedge clk);
      if (k == 3) req_valid = 2'b00;
      #1;
      check_val("both_rsp_valid", 32'(rsp_valid), 32'(exp_ready));
      check_val("both_rsp_data", 32'(rsp_data), 32'(exp_data));
      check_val("both_ready_resp", 32'(req_ready), 32'd0);
      @(negedge clk);
    end

    // address sweep from requester 1
    for (int a = 0; a < 8; a++) begin
      req_valid = 2'b10;
      req_addr  = {3'(a), 3'd0};
      #1;
      check_val("sweep_ready", 32'(req_ready), 32'd2);
      @(negedge clk);
      @(negedge clk);
      if (a == 7) req_valid = 2'b00;
      #1;
      check_val("sweep_rsp_valid", 32'(rsp_valid), 32'd2);
      check_val("sweep_rsp_data", 32'(rsp_data), 32'(2 * a));
      @(negedge clk);
    end

    // reset asserted while the read of addr 3 is in flight
    req_valid = 2'b01;
    req_addr  = {3'd0, 3'd3};
    #1;
    check_val("abort_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check_val("abort_busy_read", 32'(busy), 32'd1);
    check_val("abort_rom_addr", 32'(rom_addr), 32'd3);
    rst_n = 1'b0;
    #1;
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_rom_addr_rst", 32'(rom_addr), 32'd0);
    check_val("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("abort_rsp_data", 32'(rsp_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check_val("abort_no_rsp", 32'(rsp_valid), 32'd0);
      check_val("abort_idle", 32'(busy), 32'd0);
    end

    // normal service after the aborted read
    @(negedge clk);
    req_valid = 2'b10;
    req_addr  = {3'd6, 3'd0};
    #1;
    check_val("post_ready", 32'(req_ready), 32'd2);
    @(negedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check_val("post_rsp_valid", 32'(rsp_valid), 32'd2);
    check_val("post_rsp_data", 32'(rsp_data), 32'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
